alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the single-cycle 32-bit datapath ALU.
- Adds signed/unsigned compare split, shifts, an iterative multiplier and status flags.
- Registers every result behind a valid/ready output so the CA pipeline or a multi-cycle controller can stall on it.
- Sits between the register-file read stage and the write-back/branch logic.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8; SHW = $clog2(WIDTH).
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- in_valid  in  1  operand/op offered.
- in_ready  out  1  block accepts this cycle.
- a, b  in  WIDTH  operands.
- op  in  4  operation code (below).
- out_valid  out  1  result/flags valid and held stable.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- carry  out  1  ADD carry-out / SUB borrow.
- overflow  out  1  ADD/SUB signed overflow.
- busy  out  1  multiply in progress.

## Operation
- op codes:
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 SLT, signed compare
  - 5 SLTU, unsigned compare
  - 6 XOR
  - 7 SLL
  - 8 SRL
  - 9 SRA
  - 10 MUL, low WIDTH bits of the product
  - 11 MULHU, high WIDTH bits of the unsigned product
  - 12–15 undefined: result 0, zero = 1, carry = overflow = 0
- Shifts use b[SHW-1:0] only; upper bits of b are ignored.
- SLT/SLTU yield exactly 1 or 0, zero-extended to WIDTH.
- Arithmetic is modulo 2^WIDTH.
- carry:
  - ADD: bit WIDTH of a+b.
  - SUB: 1 iff a < b unsigned.
  - 0 for all other ops.
- overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from a.
  - 0 for all other ops.
- zero is registered together with result, never computed combinationally from it.
- FSM states:
  - IDLE → DONE: accept of ops 0–9 or 12–15; result computed and registered on the accept edge.
  - IDLE → MUL: accept of op 10 or 11; latch a, b and the op, clear the 2·WIDTH accumulator, counter = 0.
  - MUL: one shift-add step per cycle. After WIDTH steps, register the selected half → DONE.
  - DONE: out_valid = 1. If out_ready and no new accept → IDLE. If out_ready and accept → behave as IDLE accept in the same edge.
- in_ready = (state == IDLE) | (state == DONE & out_ready). It is 0 throughout MUL.
- in_valid while in_ready = 0 is ignored; no queueing.
- busy = (state == MUL).

## Timing
- Reset values: state IDLE, result 0, zero 0, carry 0, overflow 0, out_valid 0, busy 0, counter 0, in_ready 1.
- Reset is effective immediately (asynchronous) and may arrive mid-multiply: partial product discarded, any pending DONE result lost.
- Latency from accept edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL/MULHU: WIDTH+1 cycles; busy high for WIDTH cycles.
- Throughput for single-cycle ops: one per cycle while out_ready = 1.
- Output stability: while out_valid & !out_ready, result and flags hold and no new operation is accepted.
- in_ready is combinational from state and out_ready; there is no path from in_valid to in_ready.
- Operands and op are sampled only on the accept edge. For MUL they need not be held afterwards.

## Test plan
- Reset, then ADD a=0xFFFFFFFF, b=1, out_ready=1 → next cycle: out_valid=1, result=0, zero=1, carry=1, overflow=0.
- SUB a=0x80000000, b=1 → result=0x7FFFFFFF, overflow=1, carry=0. Then SLT a=0xFFFFFFFF, b=1 → 1, and SLTU with the same operands → 0.
- SRA a=0x80000000, b=0x21 → shift uses 1, result=0xC0000000. SLL a=1, b=31 → 0x80000000.
- MUL a=0xFFFFFFFF, b=2 → busy for 32 cycles, out_valid at cycle 33, result=0xFFFFFFFE. MULHU with the same operands → 0x00000001. in_valid pulses during busy are ignored.
- Back-to-back ADDs with out_ready held 1 → one result per cycle. Drop out_ready for 3 cycles → result and flags hold, in_ready=0 until released.
- Assert rst_n=0 mid-MUL at step 10 → out_valid, busy and result go 0 immediately. After release, a fresh ADD 2+3 returns 5 with correct latency.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq                                                         |
// | Purpose  : Handshaked ALU with registered result/flags. Single-cycle ops   |
// |            (add/sub/logic/compare/shift) complete on the accept edge;      |
// |            MUL/MULHU run an iterative shift-add multiplier for WIDTH cycles|
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            in_valid/in_ready  - operand handshake (a, b, op)               |
// |            out_valid/out_ready - result handshake (result, zero, carry,    |
// |                                  overflow)                                 |
// |            busy               - multiply in progress                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic accept, is_mul_op;
  logic load_alu, load_mul, start_mul;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_full, sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  // Bit WIDTH of the zero-extended difference is the unsigned borrow (a < b).
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
      default: alu_res = '0;   // MUL ops never load from here; 12-15 give 0
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative multiplier: multiplicand shifts left, multiplier shifts right,
  // one conditional add per cycle.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] mcand, acc, acc_step;
  logic [WIDTH-1:0]   mplier, mul_sel;
  logic [SHW-1:0]     cnt;
  logic               mul_hi, mul_last;

  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == SHW'(WIDTH - 1));
  assign mul_sel  = mul_hi ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul_op = (op == OP_MUL) || (op == OP_MULHU);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_alu   = 1'b0;
    load_mul   = 1'b0;
    start_mul  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        // A DONE accept implies out_ready, so it doubles as the hand-off.
        if (accept) begin
          if (is_mul_op) begin
            state_next = S_MUL;
            start_mul  = 1'b1;
          end else begin
            state_next = S_DONE;
            load_alu   = 1'b1;
          end
        end else if ((state == S_DONE) && out_ready) begin
          state_next = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_last) begin
          state_next = S_DONE;
          load_mul   = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      mul_hi   <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (start_mul) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
        mul_hi <= (op == OP_MULHU);
      end else if (state == S_MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + SHW'(1);   // wraps back to 0 on the final step
      end

      if (load_alu) begin
        result   <= alu_res;
        zero     <= (alu_res == '0);
        carry    <= alu_c;
        overflow <= alu_v;
      end else if (load_mul) begin
        result   <= mul_sel;
        zero     <= (mul_sel == '0);
        carry    <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                      |
// | Purpose  : Directed, table-driven bench for alu_seq (WIDTH = 32) with      |
// |            hand-written multiply, stall and mid-multiply reset sequences.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, carry, overflow, busy;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issue a MUL/MULHU from IDLE, poke junk into the inputs while busy and
  // check latency, busy length, ignored input and the final result.
  task automatic run_mul(input string nm, input logic [3:0] mop,
                         input logic [31:0] ma, input logic [31:0] mb,
                         input logic [31:0] exp);
    int edges;
    int busy_cyc;
    logic ready_seen;
    edges = 0;
    busy_cyc = 0;
    ready_seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op = mop; a = ma; b = mb;
    @(posedge clk); #1;
    while (!out_valid && edges < 100) begin
      @(negedge clk);
      in_valid = edges[0];
      op = 4'd0;
      a = $urandom;
      b = $urandom;
      if (busy) busy_cyc++;
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    chk({nm, " latency"}, edges, 32);
    chk({nm, " busy cycles"}, busy_cyc, 32);
    chk({nm, " in_ready during busy"}, {31'b0, ready_seen}, 32'd0);
    chk({nm, " result"}, result, exp);
    chk({nm, " flags zcv"}, {29'b0, zero, carry, overflow}, {29'b0, (exp == 32'd0), 2'b00});
    @(posedge clk); #1;
    chk({nm, " back to idle"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'd9,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd7,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd3,  32'h0F0F_0000, 32'h00F0_F00F, 32'h0FFF_F00F, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'd6,  32'hFFFF_0000, 32'h0FF0_0FF0, 32'hF00F_0FF0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'd1,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'd13, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'd7,  32'h0000_0003, 32'h0000_0020, 32'h0000_0003, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset busy",      {31'b0, busy}, 32'd0);
    chk("reset in_ready",  {31'b0, in_ready}, 32'd1);
    chk("reset result",    result, 32'd0);
    chk("reset flags zcv", {29'b0, zero, carry, overflow}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle table: one result per cycle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d result", i), result, vecs[i].res);
      chk($sformatf("v%0d flags zcv", i), {29'b0, zero, carry, overflow},
          {29'b0, vecs[i].z, vecs[i].c, vecs[i].v});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain out_valid", {31'b0, out_valid}, 32'd0);

    // Stall: hold result/flags while out_ready is low
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; a = 32'hFFFF_FFFF; b = 32'h0000_0006; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("stall first result", result, 32'h0000_0005);
    @(negedge clk);
    op = 4'd1; a = 32'd10; b = 32'd30;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d in_ready", k), {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stall%0d result", k), result, 32'h0000_0005);
      chk($sformatf("stall%0d flags zcv", k), {29'b0, zero, carry, overflow}, 32'd2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("release new result", result, 32'hFFFF_FFEC);
    chk("release flags zcv", {29'b0, zero, carry, overflow}, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Multiplier sequences
    run_mul("mul ffffffff*2",   4'd10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
    run_mul("mulhu ffffffff*2", 4'd11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    run_mul("mul 2^16*2^16",    4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run_mul("mulhu max*max",    4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mul("mul max*max",      4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    // Reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; op = 4'd10; a = 32'hFFFF_FFFF; b = 32'h0000_0002;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul reset busy",      {31'b0, busy}, 32'd0);
    chk("midmul reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("midmul reset result",    result, 32'd0);
    chk("midmul reset in_ready",  {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; op = 4'd0; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    chk("post reset out_valid", {31'b0, out_valid}, 32'd1);
    chk("post reset result",    result, 32'd5);
    chk("post reset flags zcv", {29'b0, zero, carry, overflow}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
